// File: rtl/iterative_alu.sv
// Iterative ALU: single-cycle logic/arith ops, bit-serial shifts.
// start/busy/done handshake lets the core stall around shifts.
module iterative_alu #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [3:0]            ALU_Operation_i,
  input  logic [DATA_WIDTH-1:0] A_i,
  input  logic [DATA_WIDTH-1:0] B_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] ALU_Result_o,
  output logic                  Zero_o,
  output logic                  illegal_o
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_LUI = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0101;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t                 state, state_d;
  logic [SHAMT_WIDTH-1:0] cnt, cnt_d;
  logic [DATA_WIDTH-1:0]  acc, acc_d;
  logic [DATA_WIDTH-1:0]  result, result_d;
  logic                   dir_left, dir_left_d;
  logic                   zero, zero_d;
  logic                   done, done_d;
  logic                   illegal, illegal_d;

  logic [DATA_WIDTH-1:0]  alu_val;
  logic [DATA_WIDTH-1:0]  step;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic                   is_shift;
  logic                   bad_op;

  assign shamt = B_i[SHAMT_WIDTH-1:0];
  assign step  = dir_left ? (acc << 1) : (acc >> 1);

  // Single-cycle result; a zero-amount shift passes A through
  always_comb begin
    alu_val  = '0;
    bad_op   = 1'b0;
    is_shift = 1'b0;
    case (ALU_Operation_i)
      OP_ADD:  alu_val = A_i + B_i;
      OP_LUI:  alu_val = DATA_WIDTH'({B_i[19:0], 12'h000});
      OP_OR:   alu_val = A_i | B_i;
      OP_SLL: begin
        alu_val  = A_i;
        is_shift = 1'b1;
      end
      OP_SRL: begin
        alu_val  = A_i;
        is_shift = 1'b1;
      end
      OP_SUB:  alu_val = A_i - B_i;
      default: bad_op = 1'b1;
    endcase
  end

  // Next-state and datapath updates; results hold until next completion
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    acc_d      = acc;
    dir_left_d = dir_left;
    result_d   = result;
    zero_d     = zero;
    done_d     = 1'b0;
    illegal_d  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_i) begin
          if (is_shift && shamt != '0) begin
            state_d    = SHIFT;
            acc_d      = A_i;
            cnt_d      = shamt;
            dir_left_d = (ALU_Operation_i == OP_SLL);
          end else begin
            result_d  = alu_val;
            zero_d    = (alu_val == '0);
            done_d    = 1'b1;
            illegal_d = bad_op;
          end
        end
      end
      SHIFT: begin
        acc_d = step;
        cnt_d = cnt - SHAMT_WIDTH'(1);
        if (cnt == SHAMT_WIDTH'(1)) begin
          state_d  = IDLE;
          result_d = step;
          zero_d   = (step == '0);
          done_d   = 1'b1;
        end
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      dir_left <= 1'b0;
      result   <= '0;
      zero     <= 1'b1;
      done     <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      acc      <= acc_d;
      dir_left <= dir_left_d;
      result   <= result_d;
      zero     <= zero_d;
      done     <= done_d;
      illegal  <= illegal_d;
    end
  end

  assign busy_o       = (state == SHIFT);
  assign done_o       = done;
  assign illegal_o    = illegal;
  assign ALU_Result_o = result;
  assign Zero_o       = zero;

endmodule

// File: tb/tb_iterative_alu.sv
// Bench for iterative_alu: directed cases plus random traffic,
// checked every cycle against a transaction-level model.
module tb_iterative_alu;

  logic        clk;
  logic        reset;
  logic        start_i;
  logic [3:0]  ALU_Operation_i;
  logic [31:0] A_i;
  logic [31:0] B_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] ALU_Result_o;
  logic        Zero_o;
  logic        illegal_o;

  int errors = 0;
  int checks = 0;

  iterative_alu #(
    .DATA_WIDTH (32),
    .SHAMT_WIDTH(5)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start_i        (start_i),
    .ALU_Operation_i(ALU_Operation_i),
    .A_i            (A_i),
    .B_i            (B_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .ALU_Result_o   (ALU_Result_o),
    .Zero_o         (Zero_o),
    .illegal_o      (illegal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: whole-operation arithmetic, no iteration
  task automatic ref_calc(input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] r,
                          output logic bad);
    bad = 1'b0;
    case (op)
      4'd0: r = a + b;
      4'd1: r = {b[19:0], 12'h000};
      4'd2: r = a | b;
      4'd3: r = a << b[4:0];
      4'd4: r = a >> b[4:0];
      4'd5: r = a - b;
      default: begin
        r   = '0;
        bad = 1'b1;
      end
    endcase
  endtask

  int          remain;
  logic [31:0] pend;
  logic [31:0] m_res;
  logic        m_zero;
  logic        m_done;
  logic        m_ill;

  // Model: an accepted op finishes 1+k cycles later (k = shamt of a shift)
  always @(posedge clk or negedge reset) begin
    logic [31:0] r;
    logic        bad;
    int          k;
    if (!reset) begin
      remain = 0;
      m_res  = '0;
      m_zero = 1'b1;
      m_done = 1'b0;
      m_ill  = 1'b0;
    end else begin
      m_done = 1'b0;
      m_ill  = 1'b0;
      if (remain > 0) begin
        remain--;
        if (remain == 0) begin
          m_done = 1'b1;
          m_res  = pend;
          m_zero = (pend == 0);
        end
      end else if (start_i) begin
        ref_calc(ALU_Operation_i, A_i, B_i, r, bad);
        k = (ALU_Operation_i == 4'd3 || ALU_Operation_i == 4'd4)
            ? int'(B_i[4:0]) : 0;
        if (k == 0) begin
          m_done = 1'b1;
          m_res  = r;
          m_zero = (r == 0);
          m_ill  = bad;
        end else begin
          remain = k;
          pend   = r;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (reset) begin
      check("done", 32'(done_o), 32'(m_done));
      check("illegal", 32'(illegal_o), 32'(m_ill));
      check("busy", 32'(busy_o), 32'(remain > 0));
      check("result", ALU_Result_o, m_res);
      check("zero", 32'(Zero_o), 32'(m_zero));
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic drive(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    start_i         = 1'b1;
    ALU_Operation_i = op;
    A_i             = a;
    B_i             = b;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  initial begin
    int n;
    int pulses;
    int done_at;
    logic [31:0] sa [4];
    logic [31:0] sb [4];

    reset           = 1'b0;
    start_i         = 1'b1;
    ALU_Operation_i = 4'd0;
    A_i             = 32'd3;
    B_i             = 32'd4;
    repeat (3) @(negedge clk);
    check("rst_result", ALU_Result_o, 32'h0);
    check("rst_zero", 32'(Zero_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    start_i = 1'b0;
    reset   = 1'b1;
    @(negedge clk);

    drive(4'd0, 32'd5, 32'd7);
    check("add_done", 32'(done_o), 32'd1);
    check("add_res", ALU_Result_o, 32'd12);
    check("add_zero", 32'(Zero_o), 32'd0);

    drive(4'd5, 32'd9, 32'd9);
    check("sub_done", 32'(done_o), 32'd1);
    check("sub_res0", ALU_Result_o, 32'd0);
    check("sub_zero", 32'(Zero_o), 32'd1);

    drive(4'd5, 32'd0, 32'd1);
    check("sub_wrap", ALU_Result_o, 32'hFFFF_FFFF);

    drive(4'd2, 32'hF0, 32'h0F);
    check("or_res", ALU_Result_o, 32'hFF);

    drive(4'd1, 32'd0, 32'h12345);
    check("lui_res", ALU_Result_o, 32'h1234_5000);

    drive(4'd3, 32'd1, 32'd31);
    n = 0;
    while (busy_o && n < 100) begin
      n++;
      A_i             = $urandom;
      B_i             = $urandom;
      ALU_Operation_i = 4'($urandom_range(0, 15));
      @(negedge clk);
    end
    check("sll_busy_cycles", 32'(n), 32'd31);
    check("sll_done", 32'(done_o), 32'd1);
    check("sll_res", ALU_Result_o, 32'h8000_0000);
    check("sll_zero", 32'(Zero_o), 32'd0);

    drive(4'd4, 32'h8000_0000, 32'd4);
    pulses  = 0;
    done_at = 0;
    for (int c = 1; c <= 12; c++) begin
      if (done_o) begin
        pulses++;
        done_at = c;
      end
      if (c == 2) begin
        start_i         = 1'b1;
        ALU_Operation_i = 4'd0;
        A_i             = 32'd1;
        B_i             = 32'd1;
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk);
    end
    check("srl_pulses", 32'(pulses), 32'd1);
    check("srl_latency", 32'(done_at), 32'd5);
    check("srl_res", ALU_Result_o, 32'h0800_0000);

    drive(4'd4, 32'h8000_0000, 32'h20);
    check("srl0_done", 32'(done_o), 32'd1);
    check("srl0_busy", 32'(busy_o), 32'd0);
    check("srl0_res", ALU_Result_o, 32'h8000_0000);

    for (int i = 0; i < 4; i++) begin
      sa[i] = $urandom;
      sb[i] = $urandom;
    end
    for (int i = 0; i < 4; i++) begin
      start_i         = 1'b1;
      ALU_Operation_i = 4'd0;
      A_i             = sa[i];
      B_i             = sb[i];
      @(negedge clk);
      check("b2b_done", 32'(done_o), 32'd1);
      check("b2b_res", ALU_Result_o, sa[i] + sb[i]);
    end
    start_i = 1'b0;

    drive(4'd7, 32'd5, 32'd6);
    check("ill_done", 32'(done_o), 32'd1);
    check("ill_flag", 32'(illegal_o), 32'd1);
    check("ill_res", ALU_Result_o, 32'd0);
    check("ill_zero", 32'(Zero_o), 32'd1);

    drive(4'd2, 32'h55, 32'h0);
    drive(4'd3, 32'd3, 32'd10);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    check("mid_rst_res", ALU_Result_o, 32'd0);
    check("mid_rst_zero", 32'(Zero_o), 32'd1);
    check("mid_rst_done", 32'(done_o), 32'd0);
    @(negedge clk);
    reset  = 1'b1;
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done_o) pulses++;
    end
    check("mid_rst_nodone", 32'(pulses), 32'd0);
    drive(4'd0, 32'd100, 32'd23);
    check("post_rst_done", 32'(done_o), 32'd1);
    check("post_rst_res", ALU_Result_o, 32'd123);

    for (int c = 0; c < 600; c++) begin
      start_i         = ($urandom_range(0, 3) != 0);
      ALU_Operation_i = 4'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0)
        ALU_Operation_i = 4'($urandom_range(8, 15));
      A_i = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      B_i = $urandom;
      if ($urandom_range(0, 3) == 0) B_i = A_i;
      if ($urandom_range(0, 1) == 0) B_i[4:0] = 5'($urandom_range(0, 3));
      @(negedge clk);
    end
    start_i = 1'b0;
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
